fp_addsub_pipe: RTL and testbench

//  Pipelined signed fixed-point add/subtract of Q(N1.M1) and Q(N2.M2) into Q(N.M), N=max(N1,N2), M=max(M1,M2).

---
 rtl/fp_addsub_pipe_pkg.sv | 21 ++
 rtl/fp_align.sv | 19 +
 rtl/fp_addsub_pipe.sv | 116 +++++++++++
 tb/tb_fp_addsub_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pipe_pkg.sv
// Shared compile-time helpers for the fixed-point add/sub pipeline.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package fp_addsub_pipe_pkg;

    // Larger of two Q-format field widths.
    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Alignment shift between two fractional widths.
    function automatic int absdiff_i(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Total bit width of a Q(n.m) value.
    function automatic int q_width(input int n, input int m);
        return n + m;
    endfunction

endpackage

// File: rtl/fp_align.sv
// Sign-extends one signed Q operand to OUT_W bits and left-shifts by SH to align binary points.
// Latency: combinational.
// Backpressure: none (pure datapath).
module fp_align #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 19,
    parameter int SH    = 0
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    logic [OUT_W-1:0] ext;

    // OUT_W always exceeds IN_W+SH, so only replicated sign bits are shifted out.
    assign ext  = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
    assign dout = ext << SH;

endmodule

// File: rtl/fp_addsub_pipe.sv
// Two-stage signed fixed-point add/sub of Q(N1.M1) and Q(N2.M2) into Q(N.M), wrap or saturate.
// Latency: 2 cycles from input handshake cycle to out_valid; one result per cycle sustained.
// Backpressure: valid/ready per stage; in_ready drops only when both stages hold data and out_ready=0.
module fp_addsub_pipe
    import fp_addsub_pipe_pkg::*;
#(
    parameter int N1       = 4,
    parameter int M1       = 12,
    parameter int N2       = 6,
    parameter int M2       = 10,
    parameter int SAT_MODE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [q_width(N1,M1)-1:0]      in_a,
    input  logic [q_width(N2,M2)-1:0]      in_b,
    input  logic                           in_sub,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [max_i(N1,N2)+max_i(M1,M2)-1:0] out_c,
    output logic                           out_ovf,
    output logic                           ovf_sticky,
    input  logic                           ovf_clr
);

    localparam int N    = max_i(N1, N2);
    localparam int M    = max_i(M1, M2);
    localparam int W    = N + M;
    localparam int SH   = absdiff_i(M1, M2);
    localparam int SH_A = (M1 < M2) ? SH : 0;
    localparam int SH_B = (M2 < M1) ? SH : 0;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0]   a_al;
    logic [W:0]   b_al;
    logic         s1_valid;
    logic [W:0]   s1_a;
    logic [W:0]   s1_b;
    logic         s1_ready;
    logic         s2_ready;
    logic [W:0]   sum;
    logic         ovf;
    logic [W-1:0] res;

    fp_align #(.IN_W(N1+M1), .OUT_W(W+1), .SH(SH_A)) u_align_a (
        .din  (in_a),
        .dout (a_al)
    );

    fp_align #(.IN_W(N2+M2), .OUT_W(W+1), .SH(SH_B)) u_align_b (
        .din  (in_b),
        .dout (b_al)
    );

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // One guard bit keeps the sum exact; overflow shows as disagreement of the top two bits.
    assign sum = s1_a + s1_b;
    assign ovf = sum[W] ^ sum[W-1];

    // Result selection: clamp toward the sign of the exact sum when saturating.
    always_comb begin
        res = sum[W-1:0];
        if ((SAT_MODE != 0) && ovf) begin
            res = sum[W] ? SAT_MIN : SAT_MAX;
        end
    end

    // Stage 1: capture aligned operands; B negated in W+1 bits so negating the most-negative value is exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= a_al;
                s1_b <= in_sub ? -b_al : b_al;
            end
        end
    end

    // Stage 2: register the (possibly saturated) result; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_ovf   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_c   <= res;
                out_ovf <= ovf;
            end
        end
    end

    // Sticky overflow: set by an overflowing result that actually leaves; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: saturating and wrapping instances share all inputs.
// Latency: expects out_valid two edges after the input handshake cycle.
// Backpressure: exercises output stalls, input blocking and mid-flight reset.
module tb_fp_addsub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_c;
    logic        out_ovf;
    logic        ovf_sticky;
    logic        ovf_clr;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [17:0] w_out_c;
    logic        w_out_ovf;
    logic        w_ovf_sticky;

    int n_checks;
    int n_fail;

    fp_addsub_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    fp_addsub_pipe #(.SAT_MODE(0)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (w_in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (w_out_valid),
        .out_ready  (out_ready),
        .out_c      (w_out_c),
        .out_ovf    (w_out_ovf),
        .ovf_sticky (w_ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one transaction for a single cycle (in_ready is 1 whenever this is used).
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; returns at a negedge with ok set, or reports a timeout.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: out_valid=0 after 10 cycles, required 1");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_c !== 18'h0) begin n_fail++; $display("FAIL reset_out_c: got %h want 00000", out_c); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", ovf_sticky); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wrap_in_ready: got %b want 1", w_in_ready); end
        @(posedge clk); #1;
    endtask

    // 1.5 + 2.25 = 3.75; checks exact latency.
    task automatic test_basic_add;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h1800; in_b = 16'h0900; in_sub = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %b want 1", out_valid); end
        n_checks++; if (out_c !== 18'h03C00) begin n_fail++; $display("FAIL basic_out_c: got %h want 03c00", out_c); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_out_ovf: got %b want 0", out_ovf); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    // 7.0 + 31.0 overflows: saturating gives 0x1FFFF, wrapping gives -26.0.
    task automatic test_overflow_add;
        bit ok;
        out_ready = 1'b1;
        push(16'h7000, 16'h7C00, 1'b0);
        wait_valid(ok);
        if (ok) begin
            n_checks++; if (out_c !== 18'h1FFFF) begin n_fail++; $display("FAIL ovf_sat_c: got %h want 1ffff", out_c); end
            n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sat_flag: got %b want 1", out_ovf); end
            n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap_valid: got %b want 1", w_out_valid); end
            n_checks++; if (w_out_c !== 18'h26000) begin n_fail++; $display("FAIL ovf_wrap_c: got %h want 26000", w_out_c); end
            n_checks++; if (w_out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap_flag: got %b want 1", w_out_ovf); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_set: got %b want 1", ovf_sticky); end
        n_checks++; if (w_ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap_sticky: got %b want 1", w_ovf_sticky); end
        @(posedge clk); #1;
    endtask

    // 0 - (-32.0) = +32.0 saturates; sticky rises only after the output handshake.
    task automatic test_sub_most_negative;
        bit ok;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sub_sticky_cleared: got %b want 0", ovf_sticky); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(16'h0000, 16'h8000, 1'b1);
        wait_valid(ok);
        if (ok) begin
            n_checks++; if (out_c !== 18'h1FFFF) begin n_fail++; $display("FAIL sub_out_c: got %h want 1ffff", out_c); end
            n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL sub_out_ovf: got %b want 1", out_ovf); end
            n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sub_sticky_early: got %b want 0", ovf_sticky); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL sub_sticky_after: got %b want 1", ovf_sticky); end
        @(posedge clk); #1;
    endtask

    // Six back-to-back inputs with the consumer stalled for the first 5 cycles.
    task automatic test_back_to_back;
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic [17:0] ve [6];
        int  idx;
        int  oidx;
        bit  acc;
        va[0] = 16'h1000; vb[0] = 16'h0400; vs[0] = 1'b0; ve[0] = 18'h02000; //  1.0 + 1.0
        va[1] = 16'h1000; vb[1] = 16'h0400; vs[1] = 1'b1; ve[1] = 18'h00000; //  1.0 - 1.0
        va[2] = 16'h0800; vb[2] = 16'hFC00; vs[2] = 1'b0; ve[2] = 18'h3F800; //  0.5 + -1.0
        va[3] = 16'hF000; vb[3] = 16'h0001; vs[3] = 1'b0; ve[3] = 18'h3F004; // -1.0 + 2^-10
        va[4] = 16'h8000; vb[4] = 16'h8000; vs[4] = 1'b1; ve[4] = 18'h18000; // -8.0 - -32.0
        va[5] = 16'h0003; vb[5] = 16'h0002; vs[5] = 1'b1; ve[5] = 18'h3FFFB; //  3 lsb - 8 lsb
        idx = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 40 && oidx < 6; cyc++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                in_a = va[idx]; in_b = vb[idx]; in_sub = vs[idx];
            end
            out_ready = (cyc >= 5);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc < 2) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept cyc%0d: in_ready=%b want 1", cyc, in_ready); end
            end else if (cyc <= 4) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked cyc%0d: in_ready=%b want 0", cyc, in_ready); end
                n_checks++; if (out_c !== ve[0]) begin n_fail++; $display("FAIL b2b_hold cyc%0d: out_c=%h want %h", cyc, out_c, ve[0]); end
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_valid cyc%0d: got %b want 1", cyc, out_valid); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_c !== ve[oidx] || out_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: out_c=%h ovf=%b want %h ovf=0", oidx, out_c, out_ovf, ve[oidx]);
                end
                oidx++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_checks++; if (oidx != 6) begin n_fail++; $display("FAIL b2b_count: got %0d results want 6", oidx); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: out_valid=%b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    // Reset with both stages full: nothing stale may appear afterwards.
    task automatic test_reset_midflight;
        bit seen;
        out_ready = 1'b0;
        push(16'h1000, 16'h0400, 1'b0);
        push(16'h2000, 16'h0400, 1'b0);
        in_valid = 1'b1; in_a = 16'h3000; in_b = 16'h0400; in_sub = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full: in_ready=%b want 0", in_ready); end
        #4 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL rstmid_sticky: got %b want 0", ovf_sticky); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: stale output seen=%b want 0", seen); end
        @(posedge clk); #1;
    endtask

    // Clear coinciding with an overflowing handshake loses; a lone clear wins.
    task automatic test_sticky_clear_race;
        bit ok;
        out_ready = 1'b1;
        push(16'h7000, 16'h7C00, 1'b0);
        wait_valid(ok);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b want 1", ovf_sticky); end
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL race_clear_alone: got %b want 0", ovf_sticky); end
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_basic_add;
        test_overflow_add;
        test_sub_most_negative;
        test_back_to_back;
        test_reset_midflight;
        test_sticky_clear_race;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
